// File: rtl/approx_add_pipe.sv
// approx_add_pipe: pipelined unsigned adder with per-beat exact / LOA / truncate modes.
// Latency STAGES cycles when not stalled; valid/ready with bubble-collapsing stages.
// Backpressure: in_ready is combinational from out_ready; a full stalled pipe holds STAGES beats.
// Optional error monitor enabled by defining APPROX_ADD_ERRMON_EN.
module approx_add_pipe #(
  parameter int W      = 8,
  parameter int K      = 4,
  parameter int STAGES = 2,
  parameter int ERRW   = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  input  logic [1:0]      in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W:0]      out_sum,
  input  logic            err_clr,
  output logic [ERRW-1:0] err_sum,
  output logic [W:0]      err_max,
  output logic [15:0]     err_cnt
);

  localparam int HW = W - K;

  // ---------------------------------------------------------------------
  // Operand split and the three adder flavours
  // ---------------------------------------------------------------------
  logic [K-1:0]  a_lo, b_lo;
  logic [HW-1:0] a_hi, b_hi;
  logic [HW:0]   hi_loa, hi_trunc;
  logic [W:0]    sum_exact, sum_loa, sum_trunc, sum_sel;

  assign a_lo = in_a[K-1:0];
  assign b_lo = in_b[K-1:0];
  assign a_hi = in_a[W-1:K];
  assign b_hi = in_b[W-1:K];

  assign sum_exact = {1'b0, in_a} + {1'b0, in_b};

  // LOA: the OR of the top low-part bits' AND stands in for the real low carry.
  assign hi_loa    = {1'b0, a_hi} + {1'b0, b_hi} + {{HW{1'b0}}, a_lo[K-1] & b_lo[K-1]};
  assign sum_loa   = {hi_loa, a_lo | b_lo};

  // Truncation drops the low part entirely, no carry into the high part.
  assign hi_trunc  = {1'b0, a_hi} + {1'b0, b_hi};
  assign sum_trunc = {hi_trunc, {K{1'b0}}};

  // Per-beat mode select; the reserved code behaves as exact.
  always_comb begin
    sum_sel = sum_exact;
    case (in_mode)
      2'd1:    sum_sel = sum_loa;
      2'd2:    sum_sel = sum_trunc;
      default: sum_sel = sum_exact;
    endcase
  end

  // ---------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------
  logic [STAGES-1:0] stg_vld;
  logic [W:0]        stg_sum [STAGES];
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;

  // Walk from the output back to stage 0: a stage advances when it holds a beat
  // and its successor can take it; it loads when empty or advancing.
  always_comb begin
    logic down;
    adv  = '0;
    load = '0;
    down = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i]  = stg_vld[i] & down;
      load[i] = ~stg_vld[i] | adv[i];
      down    = load[i];
    end
  end

  assign in_ready  = load[0];
  assign out_valid = stg_vld[STAGES-1];
  assign out_sum   = stg_sum[STAGES-1];

  // Stage 0 captures the selected result together with its valid tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_vld[0] <= 1'b0;
      stg_sum[0] <= '0;
    end else if (load[0]) begin
      stg_vld[0] <= in_valid;
      if (in_valid) begin
        stg_sum[0] <= sum_sel;
      end
    end
  end

  // Later stages are plain delay; a bubble upstream simply empties the stage.
  for (genvar g = 1; g < STAGES; g++) begin : g_delay
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stg_vld[g] <= 1'b0;
        stg_sum[g] <= '0;
      end else if (load[g]) begin
        stg_vld[g] <= stg_vld[g-1];
        if (stg_vld[g-1]) begin
          stg_sum[g] <= stg_sum[g-1];
        end
      end
    end
  end

`ifdef APPROX_ADD_ERRMON_EN
  // ---------------------------------------------------------------------
  // Error monitor: exact sum rides alongside each beat
  // ---------------------------------------------------------------------
  logic [W:0]    stg_exact [STAGES];
  logic [W:0]    ex_last;
  logic [W:0]    err_cur;
  logic [ERRW:0] sum_ext;
  logic          deliver;

  // Exact sum for stage 0, loaded in lockstep with the approximate result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_exact[0] <= '0;
    end else if (load[0] && in_valid) begin
      stg_exact[0] <= sum_exact;
    end
  end

  for (genvar g = 1; g < STAGES; g++) begin : g_exact
    // Exact-sum delay line mirrors the result stages.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stg_exact[g] <= '0;
      end else if (load[g] && stg_vld[g-1]) begin
        stg_exact[g] <= stg_exact[g-1];
      end
    end
  end

  assign ex_last = stg_exact[STAGES-1];
  assign deliver = out_valid & out_ready;

  // Absolute error: LOA can land above the exact value, so both directions occur.
  always_comb begin
    err_cur = '0;
    if (ex_last >= out_sum) begin
      err_cur = ex_last - out_sum;
    end else begin
      err_cur = out_sum - ex_last;
    end
  end

  assign sum_ext = {1'b0, err_sum} + {{(ERRW-W){1'b0}}, err_cur};

  // Statistics update on delivered beats only; a clear in the same cycle wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sum <= '0;
      err_max <= '0;
      err_cnt <= '0;
    end else if (err_clr) begin
      err_sum <= '0;
      err_max <= '0;
      err_cnt <= '0;
    end else if (deliver) begin
      err_sum <= sum_ext[ERRW] ? {ERRW{1'b1}} : sum_ext[ERRW-1:0];
      if (err_cur > err_max) begin
        err_max <= err_cur;
      end
      if ((err_cur != '0) && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end
`else
  // Monitor compiled out: statistics read as zero and the clear is ignored.
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_sum = '0;
  assign err_max = '0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_approx_add_pipe.sv
// Directed bench for approx_add_pipe at W=8, K=4, STAGES=2.
// Monitor expectations follow whether APPROX_ADD_ERRMON_EN is defined.
module tb_approx_add_pipe;

  localparam int W = 8;
  localparam int K = 4;
  localparam int ST = 2;
  localparam int ERRW = 24;
`ifdef APPROX_ADD_ERRMON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_a, in_b;
  logic [1:0]      in_mode;
  logic            out_valid;
  logic            out_ready;
  logic [W:0]      out_sum;
  logic            err_clr;
  logic [ERRW-1:0] err_sum;
  logic [W:0]      err_max;
  logic [15:0]     err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  approx_add_pipe #(.W(W), .K(K), .STAGES(ST), .ERRW(ERRW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .err_clr(err_clr), .err_sum(err_sum), .err_max(err_max), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent reference for the three arithmetic modes at W=8, K=4.
  function automatic logic [8:0] ref_sum(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] mode);
    logic [4:0] hi;
    case (mode)
      2'd1: begin
        hi = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, a[3] & b[3]};
        return {hi, a[3:0] | b[3:0]};
      end
      2'd2: begin
        hi = {1'b0, a[7:4]} + {1'b0, b[7:4]};
        return {hi, 4'b0000};
      end
      default: return {1'b0, a} + {1'b0, b};
    endcase
  endfunction

  // One beat through an otherwise idle pipe, checking the 2-cycle latency.
  task automatic send_chk(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] mode, input logic [8:0] exp);
    in_a = a; in_b = b; in_mode = mode; in_valid = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s in_ready got %b want 1", name, in_ready);
    end
    step();
    in_valid = 1'b0;
    in_mode = mode ^ 2'b11;          // in-flight beat must keep its own mode
    in_a = 8'hAA; in_b = 8'h55;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s early out_valid got %b want 0", name, out_valid);
    end
    step();
    n_tests++;
    if (out_valid !== 1'b1 || out_sum !== exp) begin
      n_fail++;
      $display("FAIL %s result got v=%b sum=%h want v=1 sum=%h", name, out_valid, out_sum, exp);
    end
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s duplicate out_valid got %b want 0", name, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0;
    out_ready = 1'b1; err_clr = 1'b0;
    #1 rst = 1'b1;
    #2;
    n_tests++;
    if (out_valid !== 1'b0 || out_sum !== 9'h0 || err_sum !== '0 || err_max !== '0 ||
        err_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset got v=%b sum=%h es=%h em=%h ec=%h want all 0",
               out_valid, out_sum, err_sum, err_max, err_cnt);
    end
    step(); step();
    rst = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_functional();
    send_chk("t1_mode0", 8'h3C, 8'h17, 2'd0, 9'h053);
    send_chk("t1_mode1", 8'h3C, 8'h17, 2'd1, 9'h04F);
    send_chk("t1_mode2", 8'h3C, 8'h17, 2'd2, 9'h040);
    send_chk("t1_mode3", 8'h3C, 8'h17, 2'd3, 9'h053);
  endtask

  task automatic test_carry_edge();
    send_chk("t2_mode1", 8'hFF, 8'hFF, 2'd1, 9'h1FF);
    send_chk("t2_mode2", 8'hFF, 8'hFF, 2'd2, 9'h1E0);
    send_chk("t2_mode0", 8'hFF, 8'hFF, 2'd0, 9'h1FE);
  endtask

  task automatic test_backpressure();
    logic [8:0] exp_q [3];
    logic [7:0] av [3];
    logic [7:0] bv [3];
    av = '{8'h01, 8'h10, 8'h80};
    bv = '{8'h02, 8'h20, 8'h80};
    exp_q = '{9'h003, 9'h030, 9'h100};
    out_ready = 1'b0; in_mode = 2'd0;
    for (int i = 0; i < 2; i++) begin
      in_a = av[i]; in_b = bv[i]; in_valid = 1'b1;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL t3_accept%0d in_ready got %b want 1", i, in_ready);
      end
      step();
    end
    in_a = av[2]; in_b = bv[2];
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== exp_q[0]) begin
        n_fail++;
        $display("FAIL t3_full got rdy=%b v=%b sum=%h want rdy=0 v=1 sum=%h",
                 in_ready, out_valid, out_sum, exp_q[0]);
      end
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (out_valid !== 1'b1 || out_sum !== exp_q[i]) begin
        n_fail++;
        $display("FAIL t3_drain%0d got v=%b sum=%h want v=1 sum=%h", i, out_valid, out_sum,
                 exp_q[i]);
      end
      if (i == 0) begin
        n_tests++;
        if (in_ready !== 1'b1) begin
          n_fail++; $display("FAIL t3_pass_through in_ready got %b want 1", in_ready);
        end
      end
      step();
      in_valid = 1'b0;
    end
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL t3_no_dup out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_throughput();
    logic [8:0] q [$];
    logic [8:0] exp_v;
    int got = 0;
    bit bubble = 1'b0;
    bit stall = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 110; c++) begin
      if (c < 100) begin
        in_valid = 1'b1;
        in_a = 8'($urandom_range(0, 255));
        in_b = 8'($urandom_range(0, 255));
        in_mode = 2'($urandom_range(0, 3));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && !in_ready) stall = 1'b1;
      if (c >= 2 && c < 102 && !out_valid) bubble = 1'b1;
      if (in_valid && in_ready) q.push_back(ref_sum(in_a, in_b, in_mode));
      if (out_valid && out_ready) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL t4_extra beat sum=%h with empty scoreboard", out_sum);
        end else begin
          exp_v = q.pop_front();
          if (out_sum !== exp_v) begin
            n_fail++; $display("FAIL t4_beat%0d got %h want %h", got, out_sum, exp_v);
          end
        end
        got++;
      end
      step();
    end
    n_tests++;
    if (got != 100 || bubble || stall) begin
      n_fail++;
      $display("FAIL t4_rate got beats=%0d bubble=%0b stall=%0b want 100 0 0", got, bubble, stall);
    end
  endtask

  task automatic test_monitor();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    send_chk("t5_mode1", 8'h3C, 8'h17, 2'd1, 9'h04F);
    send_chk("t5_mode2", 8'h3C, 8'h17, 2'd2, 9'h040);
    n_tests++;
    if (err_sum !== (MON ? 24'd23 : 24'd0) || err_max !== (MON ? 9'd19 : 9'd0) ||
        err_cnt !== (MON ? 16'd2 : 16'd0)) begin
      n_fail++;
      $display("FAIL t5_stats got es=%0d em=%0d ec=%0d want %0d %0d %0d", err_sum, err_max,
               err_cnt, MON ? 23 : 0, MON ? 19 : 0, MON ? 2 : 0);
    end
    send_chk("t5_carry", 8'hFF, 8'hFF, 2'd2, 9'h1E0);
    n_tests++;
    if (err_sum !== (MON ? 24'd53 : 24'd0) || err_max !== (MON ? 9'd30 : 9'd0) ||
        err_cnt !== (MON ? 16'd3 : 16'd0)) begin
      n_fail++;
      $display("FAIL t5_accum got es=%0d em=%0d ec=%0d want %0d %0d %0d", err_sum, err_max,
               err_cnt, MON ? 53 : 0, MON ? 30 : 0, MON ? 3 : 0);
    end
    // Clear lands on the same cycle an erroneous beat is delivered.
    in_a = 8'h3C; in_b = 8'h17; in_mode = 2'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    err_clr = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL t5_clr_setup out_valid got %b want 1", out_valid);
    end
    step();
    err_clr = 1'b0;
    n_tests++;
    if (err_sum !== '0 || err_max !== '0 || err_cnt !== '0) begin
      n_fail++;
      $display("FAIL t5_clear got es=%0d em=%0d ec=%0d want 0 0 0", err_sum, err_max, err_cnt);
    end
  endtask

  task automatic test_reset_midstream();
    bit stale = 1'b0;
    send_chk("t6_prime", 8'h3C, 8'h17, 2'd1, 9'h04F);
    out_ready = 1'b0;
    in_a = 8'h11; in_b = 8'h22; in_mode = 2'd0; in_valid = 1'b1;
    step(); step();
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || err_cnt !== (MON ? 16'd1 : 16'd0)) begin
      n_fail++;
      $display("FAIL t6_setup got v=%b ec=%0d want v=1 ec=%0d", out_valid, err_cnt, MON ? 1 : 0);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_sum !== 9'h0 || err_sum !== '0 || err_max !== '0 ||
        err_cnt !== '0) begin
      n_fail++;
      $display("FAIL t6_async got v=%b sum=%h es=%0d em=%0d ec=%0d want all 0",
               out_valid, out_sum, err_sum, err_max, err_cnt);
    end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (out_valid !== 1'b0) stale = 1'b1;
      step();
    end
    n_tests++;
    if (stale || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL t6_stale got stale=%0b rdy=%b want 0 1", stale, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_functional();
    test_carry_edge();
    test_backpressure();
    test_throughput();
    test_monitor();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
